// File: rtl/bcd_counter_updown_pkg.sv
// Shared constants and helpers for the BCD up/down counter.
// Holds the digit width, BCD limits, prescaler sizing and load clamp.
package bcd_counter_updown_pkg;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;
  localparam logic [BCD_W-1:0] BCD_MIN = 4'd0;

  function automatic int clog2(input int value);
    int w;
    w = 0;
    while ((1 << w) < value) begin
      w++;
    end
    return w;
  endfunction

  // A one-state prescaler still needs a 1-bit register to stay legal.
  function automatic int presc_w(input int prescale);
    return (prescale <= 1) ? 1 : clog2(prescale);
  endfunction

  function automatic logic [BCD_W-1:0] bcd_clamp(input logic [BCD_W-1:0] nibble);
    return (nibble > BCD_MAX) ? BCD_MAX : nibble;
  endfunction

endpackage

// File: rtl/bcd_counter_updown_digit.sv
// One BCD decade: loads, increments or decrements with wrap, and reports
// combinationally whether it sits at its terminal value for the current direction.
module bcd_digit
  import bcd_counter_updown_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             step_i,
  input  logic             up_i,
  input  logic             load_i,
  input  logic [BCD_W-1:0] load_nibble_i,
  output logic [BCD_W-1:0] digit_o,
  output logic             term_o
);

  logic [BCD_W-1:0] digit_q;
  logic [BCD_W-1:0] digit_d;

  always_comb begin
    digit_d = digit_q;
    if (load_i) begin
      digit_d = load_nibble_i;
    end else if (step_i) begin
      if (up_i) begin
        digit_d = (digit_q >= BCD_MAX) ? BCD_MIN : digit_q + 4'd1;
      end else begin
        digit_d = (digit_q == BCD_MIN) ? BCD_MAX : digit_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      digit_q <= BCD_MIN;
    end else begin
      digit_q <= digit_d;
    end
  end

  // Terminal flag feeds the next decade's step within the same cycle.
  assign term_o  = up_i ? (digit_q == BCD_MAX) : (digit_q == BCD_MIN);
  assign digit_o = digit_q;

endmodule

// File: rtl/bcd_counter_updown.sv
// Multi-digit BCD up/down counter with parallel load, enable and step prescaler.
// Emits registered tick, wrap-carry and load-error pulses alongside the count.
module bcd_counter_updown
  import bcd_counter_updown_pkg::*;
#(
  parameter int DIGITS   = 2,
  parameter int PRESCALE = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  enable_i,
  input  logic                  up_i,
  input  logic                  load_i,
  input  logic [4*DIGITS-1:0]   load_value_i,
  output logic [4*DIGITS-1:0]   signal_o,
  output logic                  tick_o,
  output logic                  carry_o,
  output logic                  load_error_o
);

  localparam int              PS_W    = presc_w(PRESCALE);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0]  presc_q;
  logic [PS_W-1:0]  presc_d;
  logic             tick_q;
  logic             carry_q;
  logic             load_err_q;

  logic             step;
  logic             wrap;
  logic             load_bad;
  logic [DIGITS-1:0] step_in;
  logic [DIGITS-1:0] term;
  logic [BCD_W-1:0] clamped [DIGITS];
  logic [BCD_W-1:0] digit   [DIGITS];

  // Prescaler: advances only while enabled, cleared by load.
  always_comb begin
    presc_d = presc_q;
    if (load_i) begin
      presc_d = '0;
    end else if (enable_i) begin
      presc_d = (presc_q == PS_LAST) ? '0 : presc_q + PS_W'(1);
    end
  end

  assign step = enable_i && (presc_q == PS_LAST) && !load_i;

  // Ripple the step through the decades; a digit moves only when all lower ones are terminal.
  always_comb begin
    logic run;
    run     = step;
    step_in = '0;
    for (int k = 0; k < DIGITS; k++) begin
      step_in[k] = run;
      run        = run & term[k];
    end
    wrap = run;
  end

  always_comb begin
    logic [BCD_W-1:0] nib;
    load_bad = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      nib        = load_value_i[k*BCD_W +: BCD_W];
      clamped[k] = bcd_clamp(nib);
      if (nib > BCD_MAX) begin
        load_bad = 1'b1;
      end
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .step_i        (step_in[g]),
      .up_i          (up_i),
      .load_i        (load_i),
      .load_nibble_i (clamped[g]),
      .digit_o       (digit[g]),
      .term_o        (term[g])
    );
    assign signal_o[g*BCD_W +: BCD_W] = digit[g];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      presc_q    <= '0;
      tick_q     <= 1'b0;
      carry_q    <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      tick_q     <= step;
      carry_q    <= wrap;
      load_err_q <= load_i & load_bad;
    end
  end

  assign tick_o       = tick_q;
  assign carry_o      = carry_q;
  assign load_error_o = load_err_q;

endmodule

// File: tb/tb_bcd_counter_updown.sv
// Directed bench: one counter with PRESCALE=1, one with PRESCALE=4, both two digits.
module tb_bcd_counter_updown;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       a_rst, a_en, a_up, a_load;
  logic [7:0] a_lv, a_sig;
  logic       a_tick, a_carry, a_lerr;
  logic       b_rst, b_en, b_up, b_load;
  logic [7:0] b_lv, b_sig;
  logic       b_tick, b_carry, b_lerr;

  int errors = 0;
  int checks = 0;

  bcd_counter_updown #(.DIGITS(2), .PRESCALE(1)) dut_a (
    .clk_i(clk), .rst_i(a_rst), .enable_i(a_en), .up_i(a_up), .load_i(a_load),
    .load_value_i(a_lv), .signal_o(a_sig), .tick_o(a_tick), .carry_o(a_carry),
    .load_error_o(a_lerr)
  );

  bcd_counter_updown #(.DIGITS(2), .PRESCALE(4)) dut_b (
    .clk_i(clk), .rst_i(b_rst), .enable_i(b_en), .up_i(b_up), .load_i(b_load),
    .load_value_i(b_lv), .signal_o(b_sig), .tick_o(b_tick), .carry_o(b_carry),
    .load_error_o(b_lerr)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    a_rst = 1; a_en = 1; a_up = 1; a_load = 1; a_lv = 8'hFF;
    b_rst = 1; b_en = 1; b_up = 1; b_load = 1; b_lv = 8'hFF;
    repeat (3) cyc();
    checks++;
    if (a_sig !== 8'h00 || a_tick !== 1'b0 || a_carry !== 1'b0 || a_lerr !== 1'b0) begin
      errors++;
      $display("FAIL reset_a: got sig=%h tick=%b carry=%b lerr=%b want 00 0 0 0", a_sig, a_tick, a_carry, a_lerr);
    end
    checks++;
    if (b_sig !== 8'h00 || b_tick !== 1'b0 || b_carry !== 1'b0 || b_lerr !== 1'b0) begin
      errors++;
      $display("FAIL reset_b: got sig=%h tick=%b carry=%b lerr=%b want 00 0 0 0", b_sig, b_tick, b_carry, b_lerr);
    end
    a_rst = 0; a_en = 0; a_load = 0; a_lv = 8'h00;
    b_rst = 0; b_en = 0; b_load = 0; b_lv = 8'h00;
    cyc();
    checks++;
    if (a_sig !== 8'h00 || a_tick !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: got sig=%h tick=%b want 00 0", a_sig, a_tick);
    end
  endtask

  task automatic test_up_wrap();
    int tick_bad;
    int carry_bad;
    tick_bad = 0; carry_bad = 0;
    a_up = 1; a_en = 1;
    for (int i = 1; i <= 100; i++) begin
      cyc();
      if (a_tick !== 1'b1) tick_bad++;
      if (i < 100 && a_carry !== 1'b0) carry_bad++;
      if (i == 9) begin
        checks++;
        if (a_sig !== 8'h09) begin errors++; $display("FAIL up_09: got %h want 09", a_sig); end
      end
      if (i == 10) begin
        checks++;
        if (a_sig !== 8'h10) begin errors++; $display("FAIL up_10: got %h want 10", a_sig); end
      end
      if (i == 99) begin
        checks++;
        if (a_sig !== 8'h99) begin errors++; $display("FAIL up_99: got %h want 99", a_sig); end
      end
      if (i == 100) begin
        checks++;
        if (a_sig !== 8'h00 || a_carry !== 1'b1) begin
          errors++;
          $display("FAIL up_wrap: got sig=%h carry=%b want 00 1", a_sig, a_carry);
        end
      end
    end
    checks++;
    if (tick_bad != 0) begin errors++; $display("FAIL back_to_back_tick: low cycles=%0d want 0", tick_bad); end
    checks++;
    if (carry_bad != 0) begin errors++; $display("FAIL early_carry: carry cycles=%0d want 0", carry_bad); end
    a_en = 0;
    cyc();
    checks++;
    if (a_sig !== 8'h00 || a_carry !== 1'b0 || a_tick !== 1'b0) begin
      errors++;
      $display("FAIL up_after: got sig=%h carry=%b tick=%b want 00 0 0", a_sig, a_carry, a_tick);
    end
  endtask

  task automatic test_down_wrap();
    a_up = 0; a_en = 0; a_load = 1; a_lv = 8'h10;
    cyc();
    checks++;
    if (a_sig !== 8'h10 || a_lerr !== 1'b0 || a_tick !== 1'b0) begin
      errors++;
      $display("FAIL down_load: got sig=%h lerr=%b tick=%b want 10 0 0", a_sig, a_lerr, a_tick);
    end
    a_load = 0; a_en = 1;
    cyc();
    checks++;
    if (a_sig !== 8'h09) begin errors++; $display("FAIL down_09: got %h want 09", a_sig); end
    cyc();
    checks++;
    if (a_sig !== 8'h08) begin errors++; $display("FAIL down_08: got %h want 08", a_sig); end
    repeat (8) cyc();
    checks++;
    if (a_sig !== 8'h00 || a_carry !== 1'b0) begin
      errors++;
      $display("FAIL down_00: got sig=%h carry=%b want 00 0", a_sig, a_carry);
    end
    cyc();
    checks++;
    if (a_sig !== 8'h99 || a_carry !== 1'b1 || a_tick !== 1'b1) begin
      errors++;
      $display("FAIL down_wrap: got sig=%h carry=%b tick=%b want 99 1 1", a_sig, a_carry, a_tick);
    end
    a_en = 0;
    cyc();
    checks++;
    if (a_sig !== 8'h99 || a_carry !== 1'b0) begin
      errors++;
      $display("FAIL down_after: got sig=%h carry=%b want 99 0", a_sig, a_carry);
    end
  endtask

  task automatic test_load();
    a_en = 1; a_up = 1; a_load = 1; a_lv = 8'h47;
    cyc();
    checks++;
    if (a_sig !== 8'h47 || a_tick !== 1'b0 || a_carry !== 1'b0 || a_lerr !== 1'b0) begin
      errors++;
      $display("FAIL load_47: got sig=%h tick=%b carry=%b lerr=%b want 47 0 0 0", a_sig, a_tick, a_carry, a_lerr);
    end
    a_lv = 8'hA3;
    cyc();
    checks++;
    if (a_sig !== 8'h93 || a_lerr !== 1'b1 || a_tick !== 1'b0) begin
      errors++;
      $display("FAIL load_A3: got sig=%h lerr=%b tick=%b want 93 1 0", a_sig, a_lerr, a_tick);
    end
    a_lv = 8'hFF;
    cyc();
    checks++;
    if (a_sig !== 8'h99 || a_lerr !== 1'b1 || a_carry !== 1'b0) begin
      errors++;
      $display("FAIL load_FF: got sig=%h lerr=%b carry=%b want 99 1 0", a_sig, a_lerr, a_carry);
    end
    a_lv = 8'h3C;
    cyc();
    checks++;
    if (a_sig !== 8'h39 || a_lerr !== 1'b1) begin
      errors++;
      $display("FAIL load_3C: got sig=%h lerr=%b want 39 1", a_sig, a_lerr);
    end
    a_load = 0; a_en = 0;
    cyc();
    checks++;
    if (a_sig !== 8'h39 || a_lerr !== 1'b0) begin
      errors++;
      $display("FAIL load_pulse: got sig=%h lerr=%b want 39 0", a_sig, a_lerr);
    end
  endtask

  task automatic test_prescale();
    int tick_bad;
    tick_bad = 0;
    b_up = 1; b_en = 1;
    for (int i = 1; i <= 8; i++) begin
      cyc();
      if (b_tick !== ((i % 4) == 0)) tick_bad++;
    end
    checks++;
    if (tick_bad != 0 || b_sig !== 8'h02) begin
      errors++;
      $display("FAIL presc_cont: got bad_ticks=%0d sig=%h want 0 02", tick_bad, b_sig);
    end
    tick_bad = 0;
    repeat (2) begin cyc(); if (b_tick !== 1'b0) tick_bad++; end
    b_en = 0;
    repeat (5) begin cyc(); if (b_tick !== 1'b0) tick_bad++; end
    checks++;
    if (tick_bad != 0 || b_sig !== 8'h02) begin
      errors++;
      $display("FAIL presc_hold: got bad_ticks=%0d sig=%h want 0 02", tick_bad, b_sig);
    end
    b_en = 1;
    cyc();
    checks++;
    if (b_tick !== 1'b0) begin errors++; $display("FAIL presc_resume1: got tick=%b want 0", b_tick); end
    cyc();
    checks++;
    if (b_tick !== 1'b1 || b_sig !== 8'h03) begin
      errors++;
      $display("FAIL presc_resume2: got tick=%b sig=%h want 1 03", b_tick, b_sig);
    end
    cyc();
    checks++;
    if (b_tick !== 1'b0) begin errors++; $display("FAIL presc_pulse: got tick=%b want 0", b_tick); end
  endtask

  task automatic test_reset_mid();
    int n;
    b_en = 0; b_load = 1; b_lv = 8'h58;
    cyc();
    b_load = 0; b_en = 1;
    repeat (2) cyc();
    checks++;
    if (b_sig !== 8'h58 || b_tick !== 1'b0) begin
      errors++;
      $display("FAIL mid_setup: got sig=%h tick=%b want 58 0", b_sig, b_tick);
    end
    b_rst = 1;
    cyc();
    b_rst = 0;
    checks++;
    if (b_sig !== 8'h00 || b_tick !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got sig=%h tick=%b want 00 0", b_sig, b_tick);
    end
    n = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      n++;
      if (b_tick === 1'b1) break;
    end
    checks++;
    if (n != 4 || b_tick !== 1'b1 || b_sig !== 8'h01) begin
      errors++;
      $display("FAIL mid_first_tick: got cycles=%0d tick=%b sig=%h want 4 1 01", n, b_tick, b_sig);
    end
    repeat (2) cyc();
    b_up = 0;
    repeat (2) cyc();
    checks++;
    if (b_tick !== 1'b1 || b_sig !== 8'h00 || b_carry !== 1'b0) begin
      errors++;
      $display("FAIL dir_down: got tick=%b sig=%h carry=%b want 1 00 0", b_tick, b_sig, b_carry);
    end
    b_up = 1;
    repeat (4) cyc();
    checks++;
    if (b_tick !== 1'b1 || b_sig !== 8'h01) begin
      errors++;
      $display("FAIL dir_up: got tick=%b sig=%h want 1 01", b_tick, b_sig);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_load();
    test_prescale();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bcd_counter_updown.md
# bcd_counter_updown

Synchronous multi-digit BCD up/down counter with parallel load, enable, and step prescaler. Each 4-bit digit of its output is valid BCD (0–9) and drives one BCD-to-decimal decoder. Together they form the count-and-display path of the lab datapath. The counter also produces step and wrap pulses for downstream sequencing.

## Interface
- DIGITS, 2: number of BCD decades; output width is 4*DIGITS.
- PRESCALE, 1: enabled clock cycles per count step; must be ≥1.
- clk_i  input  1  rising-edge clock.
- rst_i  input  1  synchronous, active-high reset.
- enable_i  input  1  allows counting; while low, prescaler and count hold.
- up_i  input  1  direction: 1 = increment, 0 = decrement; sampled on the step cycle.
- load_i  input  1  synchronous parallel load.
- load_value_i  input  4*DIGITS  value to load; nibble k is digit k (nibble 0 = least significant).
- signal_o  output  4*DIGITS  current count in BCD, nibble 0 = least significant.
- tick_o  output  1  one-cycle pulse, high in the same cycle that signal_o shows a stepped value.
- carry_o  output  1  one-cycle pulse on wrap: up from all-9s to 0, or down from 0 to all-9s.
- load_error_o  output  1  one-cycle pulse when a loaded nibble was greater than 9.

## Operation
- Priority per clock edge: rst_i, then load_i, then count step.
- Reset: signal_o = 0, tick_o = 0, carry_o = 0, load_error_o = 0, prescaler = 0.
- Load:
  - Digit k takes nibble k of load_value_i.
  - Any nibble greater than 9 is replaced with 9, and load_error_o pulses.
  - The prescaler clears. tick_o and carry_o stay low, even if enable_i is high.
- Prescaler: internal counter runs 0..PRESCALE-1 and advances only while enable_i = 1.
  - A step occurs when enable_i = 1 and the prescaler equals PRESCALE-1; the prescaler then returns to 0.
  - With PRESCALE = 1, every enabled cycle is a step.
- Step, up:
  - Digit 0 increments; a digit at 9 goes to 0 and carries into the next digit.
  - Digit k changes only if all lower digits were 9.
  - If every digit was 9, the result is 0 and carry_o pulses.
- Step, down:
  - Digit 0 decrements; a digit at 0 goes to 9 and borrows from the next digit.
  - Digit k changes only if all lower digits were 0.
  - If every digit was 0, the result is all-9s and carry_o pulses.
- The carry/borrow ripple across all digits resolves within one cycle. No multi-cycle propagation.
- A direction change between steps takes effect at the next step. Prescaler phase is unaffected.
- Every emitted digit is always in 0..9.

## Timing
- All outputs are registered; no combinational path from inputs to outputs.
- Step latency:
  - Inputs sampled at edge N.
  - New signal_o, plus tick_o and carry_o, are visible after edge N and held for exactly one cycle (the pulses).
- Load latency:
  - signal_o shows the loaded value after the sampling edge.
  - load_error_o is high in that same cycle only.
- Reset mid-prescale or mid-count: everything clears at that edge, and the first step after release needs PRESCALE enabled cycles.
- enable_i deasserted mid-prescale freezes the prescaler phase; re-enabling resumes from that phase.
- Back-to-back steps (PRESCALE = 1): tick_o stays high continuously while enable_i = 1.

## Structure
- Shared package/header holds:
  - BCD_MAX = 4'd9 and BCD_MIN = 4'd0.
  - Digit width constant BCD_W = 4.
  - The prescaler width function clog2(PRESCALE).
- Sub-module bcd_digit:
  - One decade, instantiated DIGITS times.
  - Inputs: step_in, up, load, load nibble.
  - Outputs: digit, plus a terminal flag (9 when up, 0 when down) that is combinational for chaining.
- Top level contains:
  - the prescaler;
  - the terminal-flag AND-chain that forms each digit's step_in;
  - the load clamp;
  - the output pulse registers.

## Test plan
- Reset: rst_i = 1 with enable_i = 1 and load_i = 1 for 3 cycles -> signal_o = 8'h00; tick_o, carry_o, load_error_o all 0.
- Up wrap (DIGITS = 2, PRESCALE = 1), enable from 00:
  - After 9 cycles signal_o = 8'h09; after 10 cycles 8'h10; after 99 cycles 8'h99.
  - Cycle 100: 8'h00 with carry_o = 1 for that cycle only.
- Down wrap: load 8'h10, then down steps -> 8'h09, 8'h08, ...; from 8'h00 the next step gives 8'h99 with carry_o = 1.
- Load:
  - load 8'h47 with enable_i = 1 -> 8'h47, tick_o = 0.
  - load 8'hA3 -> 8'h93, load_error_o = 1 for one cycle.
  - load 8'hFF -> 8'h99.
- Prescale (PRESCALE = 4): continuous enable -> one tick_o every 4 cycles. Drop enable for 5 cycles after 2 enabled cycles -> the next tick comes 2 enabled cycles after re-enable.
- Reset mid-operation:
  - At count 8'h58 with prescaler phase 2, pulse rst_i -> 8'h00.
  - The next tick arrives after exactly 4 enabled cycles.
  - Toggling up_i between steps changes only the direction of subsequent steps.
